// File: rtl/mem_write_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_write_controller
// Description : Store-side memory stage: byte-lane enables and shifted data
//               for DMEM/IMEM, plus memory-mapped IO writes (UART TX buffer,
//               counter reset pulse, LED register, AC FIFO push).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_write_controller #(
    parameter int LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instruction,
    input  logic                 inst_valid,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          store_data,
    output logic [3:0]           dmem_we,
    output logic [3:0]           imem_we,
    output logic [31:0]          mem_din,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    output logic                 counter_rst,
    output logic [LED_WIDTH-1:0] gpio_leds,
    output logic [31:0]          ac_fifo_din,
    output logic                 ac_fifo_wr_en,
    input  logic                 ac_fifo_full,
    output logic                 stall_out
);

    localparam logic [6:0] c_OPC_STORE = 7'b0100011;
    localparam logic [2:0] c_F3_SB     = 3'b000;
    localparam logic [2:0] c_F3_SH     = 3'b001;
    localparam logic [2:0] c_F3_SW     = 3'b010;
    localparam logic [7:0] c_IO_UART   = 8'h08;
    localparam logic [7:0] c_IO_CRST   = 8'h18;
    localparam logic [7:0] c_IO_LED    = 8'h30;
    localparam logic [7:0] c_IO_ACFIFO = 8'h44;

    logic [6:0]           w_opcode;
    logic [2:0]           w_funct3;
    logic [1:0]           w_off;
    logic [7:0]           w_io_off;
    logic                 w_store;
    logic                 w_do_store;
    logic                 w_sel_dmem;
    logic                 w_sel_imem;
    logic                 w_sel_io;
    logic                 w_uart_hit;
    logic                 w_crst_hit;
    logic                 w_led_hit;
    logic                 w_ac_hit;
    logic                 w_stall;
    logic [3:0]           w_lane_we;
    logic [31:0]          w_lane_din;
    logic                 w_unused;

    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_counter_rst;
    logic [LED_WIDTH-1:0] r_leds;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_off    = mem_addr[1:0];
    assign w_io_off = mem_addr[7:0];

    // rst masks the decode so every combinational output reads zero in reset
    assign w_store = !rst && inst_valid && (w_opcode == c_OPC_STORE) &&
                     ((w_funct3 == c_F3_SB) || (w_funct3 == c_F3_SH) ||
                      (w_funct3 == c_F3_SW));

    assign w_sel_dmem = (mem_addr[31:30] == 2'b00) && mem_addr[28];
    assign w_sel_imem = (mem_addr[31:29] == 3'b001);
    assign w_sel_io   = (mem_addr[31:28] == 4'b1000);

    assign w_uart_hit = w_store && w_sel_io && (w_io_off == c_IO_UART);
    assign w_crst_hit = w_store && w_sel_io && (w_io_off == c_IO_CRST);
    assign w_led_hit  = w_store && w_sel_io && (w_io_off == c_IO_LED);
    assign w_ac_hit   = w_store && w_sel_io && (w_io_off == c_IO_ACFIFO);

    // A full TX buffer only blocks if it cannot drain on this same edge
    assign w_stall    = (w_uart_hit && r_tx_valid && !uart_tx_ready) ||
                        (w_ac_hit && ac_fifo_full);
    assign w_do_store = w_store && !w_stall;

    always_comb begin
        w_lane_we  = 4'b0000;
        w_lane_din = store_data;
        case (w_funct3)
            c_F3_SB: begin
                w_lane_we  = 4'b0001 << w_off;
                w_lane_din = {4{store_data[7:0]}};
            end
            c_F3_SH: begin
                case (w_off)
                    2'd1: begin
                        w_lane_we  = 4'b0110;
                        w_lane_din = {store_data[7:0], store_data[15:0], store_data[15:8]};
                    end
                    2'd2: begin
                        w_lane_we  = 4'b1100;
                        w_lane_din = {2{store_data[15:0]}};
                    end
                    default: begin
                        // offset 3 is misaligned and wraps to the low halfword
                        w_lane_we  = 4'b0011;
                        w_lane_din = {2{store_data[15:0]}};
                    end
                endcase
            end
            c_F3_SW: begin
                w_lane_we  = 4'b1111;
                w_lane_din = store_data;
            end
            default: begin
                w_lane_we  = 4'b0000;
                w_lane_din = store_data;
            end
        endcase
    end

    assign dmem_we       = (w_do_store && w_sel_dmem) ? w_lane_we : 4'b0000;
    assign imem_we       = (w_do_store && w_sel_imem) ? w_lane_we : 4'b0000;
    assign mem_din       = rst ? 32'h0 : w_lane_din;
    assign ac_fifo_wr_en = w_do_store && w_ac_hit;
    assign ac_fifo_din   = rst ? 32'h0 : store_data;
    assign stall_out     = w_stall;

    // Load takes priority over drain so a same-cycle drain+reload keeps valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else if (w_do_store && w_uart_hit) begin
            r_tx_data  <= store_data[7:0];
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && uart_tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter_rst <= 1'b0;
            r_leds        <= '0;
        end else begin
            r_counter_rst <= w_do_store && w_crst_hit;
            if (w_do_store && w_led_hit) begin
                r_leds <= store_data[LED_WIDTH-1:0];
            end
        end
    end

    assign uart_tx_data  = r_tx_data;
    assign uart_tx_valid = r_tx_valid;
    assign counter_rst   = r_counter_rst;
    assign gpio_leds     = r_leds;

    assign w_unused = ^{instruction[31:15], instruction[11:7], mem_addr[27:8]};

endmodule
`default_nettype wire

// File: tb/tb_mem_write_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_write_controller
// Description : Directed scoreboard bench for mem_write_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_write_controller;

    localparam int         LED_WIDTH   = 8;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;
    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;

    logic                 clk;
    logic                 rst;
    logic [31:0]          instruction;
    logic                 inst_valid;
    logic [31:0]          mem_addr;
    logic [31:0]          store_data;
    logic [3:0]           dmem_we;
    logic [3:0]           imem_we;
    logic [31:0]          mem_din;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_valid;
    logic                 uart_tx_ready;
    logic                 counter_rst;
    logic [LED_WIDTH-1:0] gpio_leds;
    logic [31:0]          ac_fifo_din;
    logic                 ac_fifo_wr_en;
    logic                 ac_fifo_full;
    logic                 stall_out;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_write_controller #(.LED_WIDTH(LED_WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .inst_valid    (inst_valid),
        .mem_addr      (mem_addr),
        .store_data    (store_data),
        .dmem_we       (dmem_we),
        .imem_we       (imem_we),
        .mem_din       (mem_din),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .counter_rst   (counter_rst),
        .gpio_leds     (gpio_leds),
        .ac_fifo_din   (ac_fifo_din),
        .ac_fifo_wr_en (ac_fifo_wr_en),
        .ac_fifo_full  (ac_fifo_full),
        .stall_out     (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        inst_valid  = v;
        instruction = {17'h0, f3, 5'h0, op};
        mem_addr    = addr;
        store_data  = data;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty observed=%h required=<queued value>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        uart_tx_ready = 1'b0;
        ac_fifo_full  = 1'b0;
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h1000_0000, 32'h1111_1111);
        push("rst_dmem_we", 32'h0);
        push("rst_stall", 32'h0);
        #1;
        pop_check({28'h0, dmem_we});
        pop_check({31'h0, stall_out});
        tick();
        tick();
        push("rst_tx_valid", 32'h0);
        push("rst_tx_data", 32'h0);
        push("rst_counter_rst", 32'h0);
        push("rst_leds", 32'h0);
        pop_check({31'h0, uart_tx_valid});
        pop_check({24'h0, uart_tx_data});
        pop_check({31'h0, counter_rst});
        pop_check({24'h0, gpio_leds});
        rst = 1'b0;

        // SB to DMEM, top byte lane
        drive(1'b1, c_OPC_STORE, 3'b000, 32'h1000_0003, 32'hAABB_CCDD);
        push("sb_dmem_we", 32'h8);
        push("sb_imem_we", 32'h0);
        push("sb_din", 32'hDDDD_DDDD);
        #1;
        pop_check({28'h0, dmem_we});
        pop_check({28'h0, imem_we});
        pop_check(mem_din);
        tick();

        // SH misaligned to the dual DMEM/IMEM region
        drive(1'b1, c_OPC_STORE, 3'b001, 32'h3000_0003, 32'h0000_1234);
        push("sh3_dmem_we", 32'h3);
        push("sh3_imem_we", 32'h3);
        push("sh3_din_lo", 32'h1234);
        #1;
        pop_check({28'h0, dmem_we});
        pop_check({28'h0, imem_we});
        pop_check({16'h0, mem_din[15:0]});
        tick();

        drive(1'b1, c_OPC_STORE, 3'b001, 32'h1000_0001, 32'h0000_1234);
        push("sh1_dmem_we", 32'h6);
        push("sh1_din_mid", 32'h1234);
        #1;
        pop_check({28'h0, dmem_we});
        pop_check({16'h0, mem_din[23:8]});
        tick();

        drive(1'b1, c_OPC_STORE, 3'b010, 32'h2000_0004, 32'hCAFE_F00D);
        push("sw_imem_we", 32'hF);
        push("sw_din", 32'hCAFE_F00D);
        #1;
        pop_check({28'h0, imem_we});
        pop_check(mem_din);
        tick();

        drive(1'b1, c_OPC_STORE, 3'b010, 32'h4000_0000, 32'h1234_5678);
        push("bios_enables", 32'h0);
        #1;
        pop_check({23'h0, dmem_we, imem_we, ac_fifo_wr_en});
        tick();

        // UART: first byte, then a second that must stall until ready
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0008, 32'h0000_0041);
        push("uart1_stall", 32'h0);
        #1;
        pop_check({31'h0, stall_out});
        tick();
        push("uart1_valid", 32'h1);
        push("uart1_data", 32'h41);
        pop_check({31'h0, uart_tx_valid});
        pop_check({24'h0, uart_tx_data});
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0008, 32'h0000_0042);
        for (int i = 0; i < 2; i++) begin
            push("uart2_stall", 32'h1);
            #1;
            pop_check({31'h0, stall_out});
            tick();
            push("uart2_hold_data", 32'h41);
            pop_check({24'h0, uart_tx_data});
        end
        uart_tx_ready = 1'b1;
        push("uart2_nostall", 32'h0);
        #1;
        pop_check({31'h0, stall_out});
        tick();
        push("uart2_valid", 32'h1);
        push("uart2_data", 32'h42);
        pop_check({31'h0, uart_tx_valid});
        pop_check({24'h0, uart_tx_data});
        drive(1'b0, c_OPC_STORE, 3'b010, 32'h8000_0008, 32'h0000_0043);
        tick();
        push("uart_drained", 32'h0);
        pop_check({31'h0, uart_tx_valid});
        uart_tx_ready = 1'b0;

        // Counter reset pulse lasts exactly one cycle
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0018, 32'h0);
        tick();
        drive(1'b0, c_OPC_STORE, 3'b010, 32'h8000_0018, 32'h0);
        push("crst_high", 32'h1);
        pop_check({31'h0, counter_rst});
        tick();
        push("crst_low", 32'h0);
        pop_check({31'h0, counter_rst});

        // LED byte store, pending UART byte, then reset clears both
        drive(1'b1, c_OPC_STORE, 3'b000, 32'h8000_0030, 32'h0000_005A);
        tick();
        push("leds_5a", 32'h5A);
        pop_check({24'h0, gpio_leds});
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0008, 32'h0000_0077);
        tick();
        push("uart_pending", 32'h1);
        pop_check({31'h0, uart_tx_valid});
        drive(1'b0, c_OPC_STORE, 3'b010, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push("rst2_leds", 32'h0);
        push("rst2_tx_valid", 32'h0);
        pop_check({24'h0, gpio_leds});
        pop_check({31'h0, uart_tx_valid});

        // AC FIFO held off by full for three cycles
        ac_fifo_full = 1'b1;
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0044, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            push("ac_full_stall", 32'h1);
            push("ac_full_wr_en", 32'h0);
            #1;
            pop_check({31'h0, stall_out});
            pop_check({31'h0, ac_fifo_wr_en});
            tick();
        end
        ac_fifo_full = 1'b0;
        push("ac_wr_en", 32'h1);
        push("ac_din", 32'hDEAD_BEEF);
        push("ac_stall", 32'h0);
        #1;
        pop_check({31'h0, ac_fifo_wr_en});
        pop_check(ac_fifo_din);
        pop_check({31'h0, stall_out});
        tick();
        drive(1'b0, c_OPC_STORE, 3'b010, 32'h8000_0044, 32'hDEAD_BEEF);
        push("ac_wr_en_done", 32'h0);
        #1;
        pop_check({31'h0, ac_fifo_wr_en});

        // Inactive, non-store and bad-width instructions have no effect
        drive(1'b0, c_OPC_STORE, 3'b010, 32'h1000_0000, 32'hFFFF_FFFF);
        push("bubble_dmem_we", 32'h0);
        #1;
        pop_check({28'h0, dmem_we});
        tick();
        drive(1'b1, c_OPC_LOAD, 3'b010, 32'h8000_0030, 32'h0000_00FF);
        push("load_enables", 32'h0);
        #1;
        pop_check({23'h0, dmem_we, imem_we, stall_out});
        tick();
        push("load_leds", 32'h0);
        pop_check({24'h0, gpio_leds});
        drive(1'b1, c_OPC_STORE, 3'b011, 32'h3000_0000, 32'hFFFF_FFFF);
        push("f3_bad_enables", 32'h0);
        #1;
        pop_check({24'h0, dmem_we, imem_we});
        tick();
        drive(1'b1, c_OPC_STORE, 3'b010, 32'h8000_0050, 32'h0000_00FF);
        push("io_unknown_stall", 32'h0);
        #1;
        pop_check({30'h0, stall_out, ac_fifo_wr_en});
        tick();
        push("io_unknown_state", 32'h0);
        pop_check({22'h0, gpio_leds, uart_tx_valid, counter_rst});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_write_controller.md
Name: mem_write_controller

Overview:
- Store-side counterpart of the load data path. Decodes store instructions (SB/SH/SW) in the memory stage.
- Produces byte-lane write enables and lane-shifted write data for DMEM and IMEM.
- Performs memory-mapped IO writes: UART TX byte, cycle-counter reset, LED register, AC FIFO push.
- Contains a one-entry UART TX holding buffer with valid/ready handshake, a registered counter-reset pulse, and a stall output for back-pressure.

Parameters:
- LED_WIDTH, 8, width of the gpio_leds register.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- instruction  input  32  memory-stage instruction; opcode [6:0], funct3 [14:12]
- inst_valid  input  1  instruction is live (not bubble/flushed)
- mem_addr  input  32  effective store address
- store_data  input  32  rs2 value, unshifted
- dmem_we  output  4  DMEM byte-lane write enables
- imem_we  output  4  IMEM byte-lane write enables
- mem_din  output  32  lane-shifted write data (shared by DMEM/IMEM)
- uart_tx_data  output  8  byte offered to UART TX
- uart_tx_valid  output  1  uart_tx_data valid
- uart_tx_ready  input  1  UART TX accepts byte
- counter_rst  output  1  one-cycle pulse clearing cycle/instruction counters
- gpio_leds  output  LED_WIDTH  LED register
- ac_fifo_din  output  32  AC FIFO write data
- ac_fifo_wr_en  output  1  AC FIFO push
- ac_fifo_full  input  1  AC FIFO full
- stall_out  output  1  pipeline must hold this store and retry

Behaviour:
- store = inst_valid && opcode==OPC_STORE && funct3 in {SB,SH,SW}. Any other funct3: no effect.
- do_store = store && !stall_out.
- Region decode on mem_addr[31:28]:
  - 4'b00X1 selects DMEM.
  - 4'b001X selects IMEM. 4'b0011 selects both.
  - 4'b1000 selects IO; decode uses mem_addr[7:0].
  - All others (incl. BIOS 0100): no effect.
- Lane rules, o = mem_addr[1:0]:
  - SB: we = 4'b0001<<o; mem_din = {4{store_data[7:0]}}.
  - SH: o=0 -> 0011; o=1 -> 0110; o=2 -> 1100; o=3 -> 0011 (misaligned wraps to lowest halfword). mem_din places store_data[15:0] at the matching lanes; duplicate it in both halves.
  - SW: we = 1111 and mem_din = store_data, regardless of o.
- dmem_we / imem_we / mem_din are combinational, same cycle as do_store. Enables are 0 when not do_store.
- IO 8'h08, UART TX:
  - tx_full = uart_tx_valid.
  - Transfer occurs on an edge where uart_tx_valid && uart_tx_ready.
  - stall_out = 1 when store to 08 && tx_full && !uart_tx_ready.
  - do_store to 08 loads store_data[7:0] and sets valid at the edge.
  - Drain and reload in the same cycle: valid stays 1 and data is replaced.
  - Drain with no reload: valid goes to 0.
  - uart_tx_data must not change while valid && !ready.
- IO 8'h18: do_store sets counter_rst high for exactly the following cycle (registered). Back-to-back stores give consecutive high cycles.
- IO 8'h30: do_store loads gpio_leds <= store_data[LED_WIDTH-1:0] at the edge.
- IO 8'h44, AC FIFO:
  - stall_out = 1 when store to 44 && ac_fifo_full.
  - Otherwise ac_fifo_wr_en = do_store (combinational), ac_fifo_din = store_data.
- Unknown IO offset: no side effects, no stall.
- stall_out is combinational. While asserted, all enables are 0 and no state changes except UART drain.
- IO stores ignore funct3 width (byte/halfword/word all act). Only the low bits are used.
- Reset: uart_tx_valid=0, uart_tx_data=0, counter_rst=0, gpio_leds=0.
  - A pending UART byte is discarded on rst.
  - Combinational outputs are 0 when rst is high.

Test Plan:
- SB to 0x1000_0003, data 0xAABBCCDD -> dmem_we=1000, mem_din=0xDDDDDDDD, imem_we=0000.
- SH to 0x3000_0003, data 0x1234 -> dmem_we=imem_we=0011, mem_din[15:0]=0x1234. SW to 0x4000_0000 -> all enables 0.
- SW 0x41 to 0x8000_0008 with ready=0 -> valid=1, data=0x41 next cycle. Second store to 08 -> stall_out=1 until ready=1. On that edge data becomes the second byte, valid stays 1.
- Store to 0x8000_0018 -> counter_rst high exactly one cycle. Store 0x5A to 0x8000_0030 -> gpio_leds=0x5A. Next, rst=1 -> gpio_leds=0, uart_tx_valid=0.
- Store 0xDEADBEEF to 0x8000_0044 with ac_fifo_full=1 for 3 cycles -> stall_out=1 and wr_en=0 for those 3 cycles. When full drops: wr_en=1, din=0xDEADBEEF, one cycle.
- inst_valid=0, or a non-store opcode at any address -> all enables 0, no state change, stall_out=0.
